// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the RV32I load/store funct3 encodings, the sequencer state type,
// the byte-lane swap between little-endian words and memory lane order, and
// the legality/alignment check for an incoming request.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4,
        ERR  = 3'd5
    } lsu_state_e;

    // Memory lane k holds the byte at word offset k in bits [31-8k -: 8], so
    // converting between that order and a little-endian word reverses bytes.
    function automatic logic [31:0] lane_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // High when the access must be rejected: unknown funct3 or misaligned.
    function automatic logic access_bad(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = (off != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the execute-stage request/response and data-memory signals.
// slave  : the load/store unit side.
// master : the environment side (core request source plus data memory).
interface lsu_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_read, mem_write, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
// Inputs : funct3, byte offset within the word, memory read word (lane
//          order) and the store data of the request.
// Outputs: load_data  - addressed byte/half/word, sign or zero extended;
//          store_word - memory word with only the addressed lane(s)
//                       replaced, in lane order, ready to be written back.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] req_wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [31:0] le_word_s;
    logic [31:0] le_merged_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign le_word_s = lane_swap(mem_rdata);

    // Extract the addressed byte/half and extend it for the load result.
    always_comb begin
        byte_s = le_word_s[{offset, 3'b000} +: 8];
        half_s = le_word_s[{offset[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_W:    load_data = le_word_s;
            F3_BU:   load_data = {24'h000000, byte_s};
            F3_HU:   load_data = {16'h0000, half_s};
            default: load_data = 32'h00000000;
        endcase
    end

    // Merge the store data into the word read back from memory.
    always_comb begin
        le_merged_s = le_word_s;
        case (funct3)
            F3_B:    le_merged_s[{offset, 3'b000} +: 8]     = req_wdata[7:0];
            F3_H:    le_merged_s[{offset[1], 4'b0000} +: 16] = req_wdata[15:0];
            default: le_merged_s = req_wdata;
        endcase
        store_word = lane_swap(le_merged_s);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and a word-wide data memory
// without byte enables.
// Ports: clk, rst_n (async active-low), bus (lsu_if.slave) carrying
//        req_* (request handshake), resp_* (completion pulse and data),
//        mem_* (word-aligned memory port with registered reads).
// Sub-word stores are performed as read-modify-write; illegal or misaligned
// requests are answered with resp_err and never touch memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic  clk,
    input logic  rst_n,
    lsu_if.slave bus
);

    lsu_state_e    state_r;
    lsu_state_e    state_nx_s;
    logic          we_r;
    logic [2:0]    funct3_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic [DW-1:0] resp_rdata_r;
    logic [DW-1:0] mem_wdata_r;
    logic          err_r;
    logic          accept_s;
    logic          bad_s;
    logic          is_sw_s;
    logic [DW-1:0] load_data_s;
    logic [DW-1:0] store_word_s;

    assign accept_s = (state_r == IDLE) && bus.req_valid;
    assign bad_s    = access_bad(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign is_sw_s  = bus.req_we && (bus.req_funct3 == F3_W);

    lsu_align u_align (
        .funct3     (funct3_r),
        .offset     (addr_r[1:0]),
        .mem_rdata  (bus.mem_rdata),
        .req_wdata  (wdata_r),
        .load_data  (load_data_s),
        .store_word (store_word_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; full words skip the read, sub-word stores do not.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bad_s) begin
                        state_nx_s = ERR;
                    end else if (is_sw_s) begin
                        state_nx_s = WR;
                    end else begin
                        state_nx_s = RD;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RD:      state_nx_s = WAIT;
            WAIT: begin
                if (we_r) begin
                    state_nx_s = WR;
                end else begin
                    state_nx_s = RESP;
                end
            end
            WR:      state_nx_s = RESP;
            RESP:    state_nx_s = IDLE;
            ERR:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Request latch, write data and response registers. Response data and
    // error flag are only updated on the way into a response so they hold
    // their value until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r         <= 1'b0;
            funct3_r     <= 3'b000;
            addr_r       <= {AW{1'b0}};
            wdata_r      <= {DW{1'b0}};
            resp_rdata_r <= {DW{1'b0}};
            mem_wdata_r  <= {DW{1'b0}};
            err_r        <= 1'b0;
        end else if (accept_s) begin
            we_r     <= bus.req_we;
            funct3_r <= bus.req_funct3;
            addr_r   <= bus.req_addr;
            wdata_r  <= bus.req_wdata;
            if (bad_s) begin
                err_r        <= 1'b1;
                resp_rdata_r <= {DW{1'b0}};
            end else if (is_sw_s) begin
                mem_wdata_r <= lane_swap(bus.req_wdata);
            end
        end else begin
            case (state_r)
                WAIT: begin
                    if (we_r) begin
                        mem_wdata_r <= store_word_s;
                    end else begin
                        resp_rdata_r <= load_data_s;
                        err_r        <= 1'b0;
                    end
                end
                WR: begin
                    resp_rdata_r <= {DW{1'b0}};
                    err_r        <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready   = (state_r == IDLE);
    assign bus.resp_valid  = (state_r == RESP) || (state_r == ERR);
    assign bus.resp_err    = err_r;
    assign bus.resp_rdata  = resp_rdata_r;
    assign bus.mem_read    = (state_r == RD);
    assign bus.mem_write   = (state_r == WR);
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.mem_address = {addr_r[AW-1:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        int          rdc;
        int          wrc;
        int          waits;
        logic [31:0] wd_seen;
        logic [31:0] ad_seen;
        logic        rdy_resp;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if bus ();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       bd_we = 1'b0;
    logic [7:0] bd_addr = 8'h00;
    logic [7:0] bd_data = 8'h00;
    logic [7:0] ma;
    int total = 0;
    int bad = 0;
    txn_t r;

    assign ma = bus.mem_address[7:0];

    // Data memory: registered read, lane k = byte at address+k in [31-8k -: 8].
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else begin
            if (bus.mem_read)
                bus.mem_rdata <= {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};
            if (bus.mem_write) begin
                mem[ma]        <= bus.mem_wdata[31:24];
                mem[ma + 8'd1] <= bus.mem_wdata[23:16];
                mem[ma + 8'd2] <= bus.mem_wdata[15:8];
                mem[ma + 8'd3] <= bus.mem_wdata[7:0];
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic model_err(logic we, logic [2:0] f3, logic [31:0] addr);
        bit legal;
        int size;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size = 1 << f3[1:0];
        return !legal || ((int'(addr[1:0]) % size) != 0);
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [7:0] a);
        int n;
        logic [31:0] v;
        n = 1 << f3[1:0];
        v = 32'h0;
        for (int k = 0; k < n; k++)
            v = v | (32'(ref_mem[a + 8'(k)]) << (8 * k));
        if (!f3[2] && n < 4 && v[8 * n - 1])
            v = v | (32'hFFFFFFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
        int n;
        n = 1 << f3[1:0];
        for (int k = 0; k < n; k++)
            ref_mem[a + 8'(k)] = wd[8 * k +: 8];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // Issue one request (called at a negedge), return at the negedge of the
    // response cycle with observations. With noise, req_valid stays high with
    // junk while the unit is busy.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input bit noise, output txn_t o);
        logic [31:0] tmp;
        o = '{default: 0};
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_funct3 = f3;
        bus.req_addr = addr;
        bus.req_wdata = wd;
        while (bus.req_ready !== 1'b1 && o.waits < 20) begin
            @(negedge clk);
            o.waits++;
        end
        if (bus.req_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL accept_timeout req_ready=%b expected 1", bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (noise) begin
            tmp = $urandom();
            bus.req_we = 1'b1;
            bus.req_funct3 = 3'($urandom_range(0, 7));
            bus.req_addr = tmp;
            bus.req_wdata = $urandom();
        end else begin
            bus.req_valid = 1'b0;
        end
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (bus.mem_read === 1'b1) begin
                o.nrd++; o.rdc = cyc; o.ad_seen = bus.mem_address;
            end
            if (bus.mem_write === 1'b1) begin
                o.nwr++; o.wrc = cyc; o.wd_seen = bus.mem_wdata; o.ad_seen = bus.mem_address;
            end
            if (bus.resp_valid === 1'b1) begin
                o.lat = cyc; o.rdata = bus.resp_rdata; o.err = bus.resp_err;
                o.rdy_resp = bus.req_ready;
                break;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        if (o.lat == 0) begin
            total++; bad++;
            $display("FAIL resp_timeout no resp_valid within 12 cycles");
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        total++;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
        total++;
        if ({bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes got=%b exp=0000",
                            {bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write});
        end
        total++;
        if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.resp_rdata); end
        total++;
        if (bus.mem_wdata !== 32'h0 || bus.mem_address !== 32'h0) begin
            bad++; $display("FAIL reset_mem got wdata=%h addr=%h exp 0/0", bus.mem_wdata, bus.mem_address);
        end
    endtask

    task automatic test_lw();
        poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33); poke(8'h13, 8'h44);
        do_req(1'b0, F3_W, 32'h10, 32'h0, 1'b0, r);
        total++;
        if (r.rdata !== 32'h44332211) begin bad++; $display("FAIL lw_data got=%h exp=44332211", r.rdata); end
        total++;
        if (r.lat != 3 || r.nrd != 1 || r.nwr != 0 || r.err !== 1'b0) begin
            bad++; $display("FAIL lw_timing got lat=%0d rd=%0d wr=%0d err=%b exp 3/1/0/0", r.lat, r.nrd, r.nwr, r.err);
        end
    endtask

    task automatic test_subword_loads();
        logic [2:0]  f3s [3] = '{F3_B, F3_BU, F3_HU};
        logic [31:0] ads [3] = '{32'h13, 32'h13, 32'h12};
        logic [31:0] exps [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00008033};
        poke(8'h12, 8'h33); poke(8'h13, 8'h80);
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, f3s[i], ads[i], 32'h0, 1'b0, r);
            total++;
            if (r.rdata !== exps[i] || r.lat != 3) begin
                bad++; $display("FAIL subload_%0d got=%h lat=%0d exp=%h lat=3", i, r.rdata, r.lat, exps[i]);
            end
        end
    endtask

    task automatic test_sb_rmw();
        poke(8'h20, 8'h00); poke(8'h21, 8'h00); poke(8'h22, 8'h00); poke(8'h23, 8'h00);
        do_req(1'b1, F3_B, 32'h21, 32'h123456AB, 1'b0, r);
        model_store(F3_B, 8'h21, 32'h123456AB);
        total++;
        if (r.rdc != 1 || r.wrc != 3 || r.lat != 4 || r.nrd != 1 || r.nwr != 1) begin
            bad++; $display("FAIL sb_order got rd@%0d wr@%0d resp@%0d nrd=%0d nwr=%0d exp 1/3/4/1/1",
                            r.rdc, r.wrc, r.lat, r.nrd, r.nwr);
        end
        total++;
        if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} !== 32'h00AB0000) begin
            bad++; $display("FAIL sb_mem got=%h exp=00ab0000", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]});
        end
    endtask

    task automatic test_sw();
        do_req(1'b1, F3_W, 32'h30, 32'hDEADBEEF, 1'b0, r);
        model_store(F3_W, 8'h30, 32'hDEADBEEF);
        total++;
        if (r.wd_seen !== 32'hEFBEADDE || r.nrd != 0 || r.nwr != 1 || r.lat != 2) begin
            bad++; $display("FAIL sw_write got wdata=%h nrd=%0d nwr=%0d lat=%0d exp efbeadde/0/1/2",
                            r.wd_seen, r.nrd, r.nwr, r.lat);
        end
        do_req(1'b0, F3_W, 32'h30, 32'h0, 1'b0, r);
        total++;
        if (r.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_readback got=%h exp=deadbeef", r.rdata); end
    endtask

    task automatic test_errors();
        logic        wes [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [3] = '{F3_W, F3_H, 3'b011};
        logic [31:0] ads [3] = '{32'h31, 32'h23, 32'h10};
        for (int i = 0; i < 3; i++) begin
            do_req(wes[i], f3s[i], ads[i], 32'hFFFFFFFF, 1'b0, r);
            total++;
            if (r.err !== 1'b1 || r.rdata !== 32'h0 || r.lat != 1 || r.nrd != 0 || r.nwr != 0) begin
                bad++; $display("FAIL err_%0d got err=%b rdata=%h lat=%0d nrd=%0d nwr=%0d exp 1/0/1/0/0",
                                i, r.err, r.rdata, r.lat, r.nrd, r.nwr);
            end
        end
    endtask

    task automatic test_reset_mid_rmw();
        logic seen_wr;
        seen_wr = 1'b0;
        poke(8'h40, 8'h5A); poke(8'h41, 8'hC3); poke(8'h42, 8'h96); poke(8'h43, 8'h0F);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_H;
        bus.req_addr = 32'h40; bus.req_wdata = 32'h0000BEEF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        total++;
        if (bus.mem_read !== 1'b1) begin bad++; $display("FAIL abort_rd got=%b exp=1", bus.mem_read); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} !== 4'b0000 ||
            bus.resp_rdata !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_address !== 32'h0) begin
            bad++; $display("FAIL abort_clear got v/e/r/w=%b rdata=%h wdata=%h addr=%h exp all 0",
                            {bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write},
                            bus.resp_rdata, bus.mem_wdata, bus.mem_address);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.mem_write === 1'b1) seen_wr = 1'b1;
            rst_n = 1'b1;
        end
        total++;
        if (bus.req_ready !== 1'b1 || seen_wr !== 1'b0) begin
            bad++; $display("FAIL abort_after got ready=%b write_seen=%b exp 1/0", bus.req_ready, seen_wr);
        end
        total++;
        if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !==
            {ref_mem[8'h40], ref_mem[8'h41], ref_mem[8'h42], ref_mem[8'h43]}) begin
            bad++; $display("FAIL abort_mem got=%h exp=%h", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]},
                            {ref_mem[8'h40], ref_mem[8'h41], ref_mem[8'h42], ref_mem[8'h43]});
        end
    endtask

    // Random back-to-back traffic, some with req_valid junk while busy.
    task automatic test_random();
        logic we, e_err;
        logic [2:0] f3;
        logic [31:0] addr, wd, e_rd;
        int pick, e_lat, e_nrd, e_nwr, diffs;
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin pick = $urandom_range(0, 4); f3 = (pick > 2) ? 3'(pick + 1) : 3'(pick); end
            addr = $urandom();
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            wd = $urandom();
            e_err = model_err(we, f3, addr);
            e_lat = e_err ? 1 : (we && f3 == F3_W) ? 2 : !we ? 3 : 4;
            e_rd  = (e_err || we) ? 32'h0 : model_load(f3, addr[7:0]);
            e_nrd = (!e_err && !(we && f3 == F3_W)) ? 1 : 0;
            e_nwr = (!e_err && we) ? 1 : 0;
            do_req(we, f3, addr, wd, 1'($urandom_range(0, 1)), r);
            total++;
            if (r.rdata !== e_rd || r.err !== e_err) begin
                bad++; $display("FAIL rnd%0d_data we=%b f3=%0d a=%h got=%h/%b exp=%h/%b",
                                i, we, f3, addr, r.rdata, r.err, e_rd, e_err);
            end
            total++;
            if (r.lat != e_lat || r.nrd != e_nrd || r.nwr != e_nwr) begin
                bad++; $display("FAIL rnd%0d_seq got lat=%0d nrd=%0d nwr=%0d exp %0d/%0d/%0d",
                                i, r.lat, r.nrd, r.nwr, e_lat, e_nrd, e_nwr);
            end
            if (!e_err) begin
                total++;
                if (r.ad_seen !== {addr[31:2], 2'b00}) begin
                    bad++; $display("FAIL rnd%0d_addr got=%h exp=%h", i, r.ad_seen, {addr[31:2], 2'b00});
                end
            end
            if (i > 0) begin
                total++;
                if (r.waits != 1 || r.rdy_resp !== 1'b0) begin
                    bad++; $display("FAIL rnd%0d_b2b got waits=%0d ready_in_resp=%b exp 1/0", i, r.waits, r.rdy_resp);
                end
            end
            if (!e_err && we) model_store(f3, addr[7:0], wd);
        end
        diffs = 0;
        for (int k = 0; k < 256; k++)
            if (mem[k] !== ref_mem[k]) diffs++;
        total++;
        if (diffs != 0) begin bad++; $display("FAIL rnd_memory got %0d differing bytes exp 0", diffs); end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        #2;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 256; k++) poke(8'(k), 8'($urandom_range(0, 255)));
        test_lw();
        test_subword_loads();
        test_sb_rmw();
        test_sw();
        test_errors();
        test_reset_mid_rmw();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
